window_scan_ctrl: RTL and testbench
===================================

WINDOW_SCAN_CTRL -- requirements
Module: window_scan_ctrl

Interface
REQ-001 SHALL have parameter IMG_ROWS, default 256, meaning padded-image row count (min 3).
REQ-002 SHALL have parameter IMG_COLS, default 256, meaning padded-image column count (min 3).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to filter the whole image.
REQ-006 SHALL have port busy  output  1  high from the cycle after an accepted start until done.
REQ-007 SHALL have port done  output  1  one-cycle pulse after the last write.
REQ-008 SHALL have port rd  output  1  window-read strobe to memory.
REQ-009 SHALL have ports addr_row_r and addr_col_r  output  8 each  top-left corner of the 3x3 read window.
REQ-010 SHALL have ports sw_pixel_1..sw_pixel_9  input  8 each  window from memory, row-major, sw_pixel_1 = top-left.
REQ-011 SHALL have port wr  output  1  write strobe for the filtered pixel.
REQ-012 SHALL have ports addr_row_w and addr_col_w  output  8 each  write address of the filtered pixel.
REQ-013 SHALL have port cl_pixel  output  8  filtered pixel value.

Function
REQ-014 SHALL implement FSM states IDLE, READ, CALC, WRITE, DONE.
REQ-015 SHALL leave IDLE for READ only when start=1 in IDLE; start in any other state is ignored.
REQ-016 SHALL, in READ, assert rd=1 for exactly one cycle with addr_row_r=r, addr_col_r=c; then go to CALC.
REQ-017 SHALL treat memory read latency as one cycle: sw_pixel_* sampled in CALC, registered into cl_pixel; then go to WRITE.
REQ-018 SHALL compute cl_pixel = (1*p1+2*p2+1*p3+2*p4+4*p5+2*p6+1*p7+2*p8+1*p9 + 8) >> 4, 12-bit sum, no overflow, result in 0..255.
REQ-019 SHALL, in WRITE, assert wr=1 for exactly one cycle with addr_row_w=r+1, addr_col_w=c+1 (window centre).
REQ-020 SHALL scan raster order: c increments 0..IMG_COLS-3; on wrap c=0 and r increments 0..IMG_ROWS-3.
REQ-021 SHALL go WRITE->DONE after the write at r=IMG_ROWS-3, c=IMG_COLS-3, else WRITE->READ with next (r,c).
REQ-022 SHALL assert done=1 for one cycle in DONE, then return to IDLE with r=c=0.
REQ-023 SHALL take exactly 3*(IMG_ROWS-2)*(IMG_COLS-2) cycles from READ entry to DONE entry.
REQ-024 SHALL never assert rd and wr in the same cycle.
REQ-025 SHALL hold addresses and cl_pixel stable while their strobe is low.

Reset
REQ-026 SHALL, on rst=1 at any time including mid-scan, immediately force IDLE, r=c=0, and all outputs (busy, done, rd, wr, addresses, cl_pixel) to 0.
REQ-027 SHALL require a fresh start after reset release; no scan resumes.

Configuration
REQ-028 SHALL support macro WINDOW_SCAN_PIX_CNT_EN; when defined, add output pix_count (16 bits), cleared on reset and on accepted start, incremented on each wr.
REQ-029 SHALL, without WINDOW_SCAN_PIX_CNT_EN, omit port pix_count and its logic entirely; all other behaviour identical.

Structure
REQ-030 SHALL place the FSM state enum, PIXEL_W=8, ADDR_W=8 and SUM_W=12 constants in shared package img_pkg.
REQ-031 SHALL implement the kernel arithmetic as combinational sub-module gauss3x3 (nine 8-bit inputs, one 8-bit output).

Verification
REQ-032 SHALL check: IMG_ROWS=IMG_COLS=4, start -> 4 writes to (1,1),(1,2),(2,1),(2,2) in order, done 12 cycles after READ entry.
REQ-033 SHALL check: all window pixels 0xFF -> cl_pixel=0xFF; all 0x00 -> 0x00; only centre 0x10 -> 0x04.
REQ-034 SHALL check: p1..p9 = 1..9 -> sum 80, cl_pixel = 0x05.
REQ-035 SHALL check: rst pulsed during the second CALC -> all outputs 0 at once, no further wr, busy=0 until new start.
REQ-036 SHALL check: start held high through whole scan -> exactly one scan, one done pulse, then new scan only from IDLE.
REQ-037 SHALL check: with WINDOW_SCAN_PIX_CNT_EN, 256x256 scan -> pix_count=64516 (0xFC04) at done.

Source files
------------

// File: rtl/img_pkg.sv
// Shared image-filter types and widths: scan FSM states and pixel/address/sum widths.
package img_pkg;

    localparam int unsigned PIXEL_W = 8;
    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned SUM_W   = 12;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_CALC  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } scan_state_t;

endpackage

// File: rtl/gauss3x3.sv
// Combinational 3x3 Gaussian kernel (1-2-1 / 2-4-2 / 1-2-1) with round-to-nearest divide by 16.
module gauss3x3
    import img_pkg::*;
(
    input  logic [PIXEL_W-1:0] p1,
    input  logic [PIXEL_W-1:0] p2,
    input  logic [PIXEL_W-1:0] p3,
    input  logic [PIXEL_W-1:0] p4,
    input  logic [PIXEL_W-1:0] p5,
    input  logic [PIXEL_W-1:0] p6,
    input  logic [PIXEL_W-1:0] p7,
    input  logic [PIXEL_W-1:0] p8,
    input  logic [PIXEL_W-1:0] p9,
    output logic [PIXEL_W-1:0] q
);

    logic [SUM_W-1:0] sum;

    // Worst case 16*255 + 8 = 4088 fits in the sum width without overflow.
    always_comb begin
        sum = SUM_W'(p1) + (SUM_W'(p2) << 1) + SUM_W'(p3)
            + (SUM_W'(p4) << 1) + (SUM_W'(p5) << 2) + (SUM_W'(p6) << 1)
            + SUM_W'(p7) + (SUM_W'(p8) << 1) + SUM_W'(p9)
            + SUM_W'(8);
        q   = PIXEL_W'(sum >> 4);
    end

endmodule

// File: rtl/window_scan_ctrl.sv
// Raster-scans a padded image with a 3x3 window, filters each window and writes the centre pixel.
// Optional WINDOW_SCAN_PIX_CNT_EN adds a 16-bit written-pixel counter output pix_count.
module window_scan_ctrl
    import img_pkg::*;
#(
    parameter int unsigned IMG_ROWS = 256,
    parameter int unsigned IMG_COLS = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               rd,
    output logic [ADDR_W-1:0]  addr_row_r,
    output logic [ADDR_W-1:0]  addr_col_r,
    input  logic [PIXEL_W-1:0] sw_pixel_1,
    input  logic [PIXEL_W-1:0] sw_pixel_2,
    input  logic [PIXEL_W-1:0] sw_pixel_3,
    input  logic [PIXEL_W-1:0] sw_pixel_4,
    input  logic [PIXEL_W-1:0] sw_pixel_5,
    input  logic [PIXEL_W-1:0] sw_pixel_6,
    input  logic [PIXEL_W-1:0] sw_pixel_7,
    input  logic [PIXEL_W-1:0] sw_pixel_8,
    input  logic [PIXEL_W-1:0] sw_pixel_9,
`ifdef WINDOW_SCAN_PIX_CNT_EN
    output logic [15:0]        pix_count,
`endif
    output logic               wr,
    output logic [ADDR_W-1:0]  addr_row_w,
    output logic [ADDR_W-1:0]  addr_col_w,
    output logic [PIXEL_W-1:0] cl_pixel
);

    localparam logic [ADDR_W-1:0] LAST_R = ADDR_W'(IMG_ROWS - 3);
    localparam logic [ADDR_W-1:0] LAST_C = ADDR_W'(IMG_COLS - 3);

    scan_state_t        state;
    logic [ADDR_W-1:0]  r;
    logic [ADDR_W-1:0]  c;
    logic [PIXEL_W-1:0] kernel_q;

    gauss3x3 u_gauss (
        .p1 (sw_pixel_1),
        .p2 (sw_pixel_2),
        .p3 (sw_pixel_3),
        .p4 (sw_pixel_4),
        .p5 (sw_pixel_5),
        .p6 (sw_pixel_6),
        .p7 (sw_pixel_7),
        .p8 (sw_pixel_8),
        .p9 (sw_pixel_9),
        .q  (kernel_q)
    );

    // Strobes are registered on entry to READ/WRITE so they last exactly one state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            r          <= '0;
            c          <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            rd         <= 1'b0;
            wr         <= 1'b0;
            addr_row_r <= '0;
            addr_col_r <= '0;
            addr_row_w <= '0;
            addr_col_w <= '0;
            cl_pixel   <= '0;
        end else begin
            rd   <= 1'b0;
            wr   <= 1'b0;
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_READ;
                        busy       <= 1'b1;
                        rd         <= 1'b1;
                        addr_row_r <= r;
                        addr_col_r <= c;
                    end
                end
                ST_READ: begin
                    state <= ST_CALC;
                end
                ST_CALC: begin
                    state      <= ST_WRITE;
                    cl_pixel   <= kernel_q;
                    wr         <= 1'b1;
                    addr_row_w <= r + ADDR_W'(1);
                    addr_col_w <= c + ADDR_W'(1);
                end
                ST_WRITE: begin
                    if (r == LAST_R && c == LAST_C) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        r     <= '0;
                        c     <= '0;
                    end else if (c == LAST_C) begin
                        state      <= ST_READ;
                        rd         <= 1'b1;
                        c          <= '0;
                        r          <= r + ADDR_W'(1);
                        addr_col_r <= '0;
                        addr_row_r <= r + ADDR_W'(1);
                    end else begin
                        state      <= ST_READ;
                        rd         <= 1'b1;
                        c          <= c + ADDR_W'(1);
                        addr_col_r <= c + ADDR_W'(1);
                        addr_row_r <= r;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    r     <= '0;
                    c     <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef WINDOW_SCAN_PIX_CNT_EN
    // Counts completed writes of the current scan; restarts on each accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_count <= '0;
        end else if (state == ST_IDLE && start) begin
            pix_count <= '0;
        end else if (wr) begin
            pix_count <= pix_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Directed bench for window_scan_ctrl on a 4x4 padded image with a one-cycle-latency window memory model.
`timescale 1ns/1ps
module tb_window_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy, done, rd, wr;
    logic [7:0] addr_row_r, addr_col_r, addr_row_w, addr_col_w, cl_pixel;
    logic [7:0] sw [9];
`ifdef WINDOW_SCAN_PIX_CNT_EN
    logic [15:0] pix_count;
`endif

    logic [7:0] img [4][4];

    int         n_checks = 0;
    int         n_errors = 0;

    int         n_wr, n_done, t_read, t_done, n_overlap;
    logic [7:0] w_row [8];
    logic [7:0] w_col [8];
    logic [7:0] w_pix [8];

    always #5 clk = ~clk;

    window_scan_ctrl #(.IMG_ROWS(4), .IMG_COLS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .rd         (rd),
        .addr_row_r (addr_row_r),
        .addr_col_r (addr_col_r),
        .sw_pixel_1 (sw[0]),
        .sw_pixel_2 (sw[1]),
        .sw_pixel_3 (sw[2]),
        .sw_pixel_4 (sw[3]),
        .sw_pixel_5 (sw[4]),
        .sw_pixel_6 (sw[5]),
        .sw_pixel_7 (sw[6]),
        .sw_pixel_8 (sw[7]),
        .sw_pixel_9 (sw[8]),
`ifdef WINDOW_SCAN_PIX_CNT_EN
        .pix_count  (pix_count),
`endif
        .wr         (wr),
        .addr_row_w (addr_row_w),
        .addr_col_w (addr_col_w),
        .cl_pixel   (cl_pixel)
    );

    // Window memory: answers a read strobe one cycle later.
    always @(posedge clk) begin
        if (rd) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    sw[i*3+j] <= img[int'(addr_row_r) + i][int'(addr_col_r) + j];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_img(input logic [7:0] v);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                img[i][j] = v;
    endtask

    // Starts a scan and records every write until done or a cycle budget runs out.
    task automatic run_scan(input bit hold);
        int cyc;
        cyc = 0; n_wr = 0; n_done = 0; t_read = -1; t_done = -1; n_overlap = 0;
        @(negedge clk);
        start = 1'b1;
        while (n_done == 0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (!hold) start = 1'b0;
            if (rd && t_read < 0) t_read = cyc;
            if (rd && wr) n_overlap++;
            if (wr) begin
                if (n_wr < 8) begin
                    w_row[n_wr] = addr_row_w;
                    w_col[n_wr] = addr_col_w;
                    w_pix[n_wr] = cl_pixel;
                end
                n_wr++;
            end
            if (done) begin
                n_done++;
                t_done = cyc;
            end
        end
        check("scan_done_seen", 32'(n_done), 32'd1);
    endtask

    task automatic verify_scan(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                               input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        check({tag, "_nwr"}, 32'(n_wr), 32'd4);
        check({tag, "_rdwr_overlap"}, 32'(n_overlap), 32'd0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s_pix%0d", tag, k), 32'(w_pix[k]), 32'(e[k]));
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        fill_img(8'h00);
        for (int k = 0; k < 9; k++) sw[k] = 8'h00;
        repeat (2) @(negedge clk);
        check("reset_outputs", 32'({busy, done, rd, wr}), 32'd0);
        check("reset_addr_pix", {addr_row_w, addr_col_w, cl_pixel, addr_row_r}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // All 0xFF: every window filters to 0xFF; check order and latency too.
        fill_img(8'hFF);
        run_scan(1'b0);
        verify_scan("ones", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("addr_row%0d", k), 32'(w_row[k]), 32'(1 + k / 2));
            check($sformatf("addr_col%0d", k), 32'(w_col[k]), 32'(1 + k % 2));
        end
        check("done_latency", 32'(t_done - t_read), 32'd12);
        check("busy_during_done", 32'(busy), 32'd0);
`ifdef WINDOW_SCAN_PIX_CNT_EN
        check("pix_count_at_done", 32'(pix_count), 32'd4);
`endif
        @(negedge clk);
        check("done_one_cycle", 32'({done, busy}), 32'd0);

        fill_img(8'h00);
        run_scan(1'b0);
        verify_scan("zeros", 8'h00, 8'h00, 8'h00, 8'h00);

        // Single 0x10 at (1,1): weights 4,2,2,1 across the four windows.
        fill_img(8'h00);
        img[1][1] = 8'h10;
        run_scan(1'b0);
        verify_scan("centre", 8'h04, 8'h02, 8'h02, 8'h01);

        // 1..9 in the top-left 3x3: sums 80,68,84,69 (+8, >>4).
        fill_img(8'h00);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                img[i][j] = 8'(i * 3 + j + 1);
        run_scan(1'b0);
        verify_scan("ramp", 8'h05, 8'h04, 8'h05, 8'h04);

        // Reset during the second CALC state.
        fill_img(8'hFF);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_reset_state", 32'({busy, rd, wr, cl_pixel}), 32'h4FF);
        rst = 1'b1;
        #1;
        check("mid_reset_pix_addr", {cl_pixel, addr_row_w, addr_col_w, addr_row_r}, 32'd0);
        check("mid_reset_ctrl", 32'({busy, done, rd, wr, addr_col_r}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        begin
            int seen = 0;
            repeat (20) begin
                @(negedge clk);
                if (wr || busy || rd) seen++;
            end
            check("no_resume_after_reset", 32'(seen), 32'd0);
        end

        // Start held high across a whole scan.
        fill_img(8'h00);
        run_scan(1'b1);
        verify_scan("held", 8'h00, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        check("held_idle_gap", 32'({busy, rd, done}), 32'd0);
        @(negedge clk);
        check("held_restart_from_idle", 32'({busy, rd}), 32'd3);
        start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
